// File: rtl/scaler_sequencer.sv
// scaler_sequencer: per-channel controller for one (a+d)*b+c scaler with a 4-stage pipeline.
// Ports:
//   clk, clr_n                    clock, asynchronous active-low reset
//   start, stop, busy, done       run control and status
//   cfg_we/addr/offs/scale/bias   channel-table write port (IDLE only)
//   cfg_len, cfg_err              vector length (0 = NCH), sticky write-while-busy flag
//   in_valid/in_ready/in_data     sample stream
//   sc_clr, sc_a..sc_d, sc_p      scaler operands and result
//   out_valid/out_ready/out_data/out_last  result stream from the output FIFO
module scaler_sequencer #(
    parameter int unsigned BA     = 27,
    parameter int unsigned BB     = 16,
    parameter int unsigned BC     = 27,
    parameter int unsigned BD     = 27,
    parameter int unsigned BP     = 45,
    parameter int unsigned NCH    = 64,
    parameter int unsigned FDEPTH = 8,
    localparam int unsigned CW    = $clog2(NCH)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    input  logic          cfg_we,
    input  logic [CW-1:0] cfg_addr,
    input  logic [BA-1:0] cfg_offs,
    input  logic [BB-1:0] cfg_scale,
    input  logic [BC-1:0] cfg_bias,
    input  logic [CW:0]   cfg_len,
    output logic          cfg_err,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BD-1:0] in_data,
    output logic          sc_clr,
    output logic [BA-1:0] sc_a,
    output logic [BB-1:0] sc_b,
    output logic [BC-1:0] sc_c,
    output logic [BD-1:0] sc_d,
    input  logic [BP-1:0] sc_p,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BP-1:0] out_data,
    output logic          out_last
);

    localparam int unsigned AW = $clog2(FDEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [BA-1:0] r_offs  [NCH];
    logic [BB-1:0] r_scale [NCH];
    logic [BC-1:0] r_bias  [NCH];

    logic [1:0]    r_state;
    logic [1:0]    w_state_d;
    logic          r_done;
    logic          r_err;
    logic          r_clr;
    logic [CW-1:0] r_ch;
    logic [CW:0]   r_len;
    logic [2:0]    r_inflight;
    logic [BB-1:0] r_b;
    logic [BC-1:0] r_c1;
    logic [BC-1:0] r_c2;
    logic [3:0]    r_vld;
    logic [3:0]    r_lst;

    logic [BP:0]   r_mem [FDEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_fifo_cnt;

    logic          w_busy;
    logic          w_start;
    logic          w_issue;
    logic          w_last_ch;
    logic          w_drained;
    logic          w_fifo_we;
    logic          w_fifo_re;
    logic [AW+1:0] w_credit;
    logic [CW:0]   w_len_start;

    assign w_busy    = (r_state != StIdle);
    assign w_start   = start && (r_state == StIdle);
    assign w_fifo_we = r_vld[3];
    assign w_fifo_re = out_valid && out_ready;
    assign w_drained = (r_inflight == 3'd0) && (r_fifo_cnt == '0);

    // Credits cover every result that may still land in the FIFO, so a write never meets a
    // full FIFO even though the scaler pipeline cannot be stalled.
    assign w_credit  = {1'b0, r_fifo_cnt} + (AW+2)'(r_inflight);
    assign in_ready  = (r_state == StRun) && (w_credit < (AW+2)'(FDEPTH));
    assign w_issue   = in_valid && in_ready;

    assign w_len_start = (cfg_len == '0) ? (CW+1)'(NCH) : cfg_len;
    assign w_last_ch   = ({1'b0, r_ch} == (r_len - (CW+1)'(1)));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (start)     w_state_d = StRun;
            StRun:   if (stop)      w_state_d = StDrain;
            StDrain: if (w_drained) w_state_d = StIdle;
            default:                w_state_d = StIdle;
        endcase
    end

    // Table is deliberately not reset.
    always_ff @(posedge clk) begin
        if (cfg_we && !w_busy) begin
            r_offs[cfg_addr]  <= cfg_offs;
            r_scale[cfg_addr] <= cfg_scale;
            r_bias[cfg_addr]  <= cfg_bias;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= StIdle;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_clr      <= 1'b1;
            r_ch       <= '0;
            r_len      <= (CW+1)'(NCH);
            r_inflight <= 3'd0;
            r_b        <= '0;
            r_c1       <= '0;
            r_c2       <= '0;
            r_vld      <= '0;
            r_lst      <= '0;
        end else begin
            r_state <= w_state_d;
            r_done  <= (r_state == StDrain) && w_drained;
            r_clr   <= 1'b0;

            if (w_start) begin
                r_err <= 1'b0;
            end else if (cfg_we && w_busy) begin
                r_err <= 1'b1;
            end

            if (w_start) begin
                r_len <= w_len_start;
                r_ch  <= '0;
            end else if (w_issue) begin
                r_ch <= w_last_ch ? '0 : r_ch + CW'(1);
            end

            unique case ({w_issue, w_fifo_we})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase

            // b lags a/d by one cycle, c by two, matching the scaler's register stages.
            r_b   <= w_issue ? r_scale[r_ch] : '0;
            r_c1  <= w_issue ? r_bias[r_ch] : '0;
            r_c2  <= r_c1;
            r_vld <= {r_vld[2:0], w_issue};
            r_lst <= {r_lst[2:0], w_issue && w_last_ch};
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_we) begin
            r_mem[r_wp] <= {r_lst[3], sc_p};
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_fifo_we) r_wp <= r_wp + AW'(1);
            if (w_fifo_re) r_rp <= r_rp + AW'(1);
            unique case ({w_fifo_we, w_fifo_re})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (AW+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (AW+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign sc_a = w_issue ? r_offs[r_ch] : '0;
    assign sc_d = w_issue ? in_data : '0;
    assign sc_b = r_b;
    assign sc_c = r_c2;

    assign sc_clr    = r_clr;
    assign busy      = w_busy;
    assign done      = r_done;
    assign cfg_err   = r_err;
    assign out_valid = (r_fifo_cnt != '0);
    assign out_data  = r_mem[r_rp][BP-1:0];
    assign out_last  = out_valid && r_mem[r_rp][BP];

endmodule
